// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: key codes, scan defaults and the row/column key map shared with the image generator
package keypad_scanner_pkg;
  localparam int SCAN_DIV_DEF = 25000;
  localparam int DEBOUNCE_SCANS_DEF = 4;
  localparam logic [3:0] KEY_UP = 4'd2;
  localparam logic [3:0] KEY_DOWN = 4'd8;
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } cand_t;
  // key '0' has code 0, so "no key" needs the separate valid bit
  localparam cand_t KEY_NONE = '{valid: 1'b0, code: 4'd0};
  localparam logic [3:0] KEY_TABLE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[{r, c}];
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus debounced key outputs
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_event;
  modport master (input col_n, output row_n, key_code, key_pressed, key_event);
  modport slave (output col_n, input row_n, key_code, key_pressed, key_event);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a frame candidate after DEBOUNCE_SCANS identical frames
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_end,
  input  cand_t      cand,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       key_event
);
  cand_t      prev;
  logic [3:0] stable;
  logic [3:0] nxt;
  always_comb nxt = cand != prev ? 4'd1 : stable == 4'(DEBOUNCE_SCANS) ? stable : stable + 4'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= KEY_NONE;
      stable <= '0;
      key_code <= '0;
      key_pressed <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (frame_end) begin
        prev <= cand;
        stable <= nxt;
        if (nxt == 4'(DEBOUNCE_SCANS)) begin
          key_pressed <= cand.valid;
          key_code <= cand.code;
          key_event <= cand.valid && (!key_pressed || key_code != cand.code);
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix row scan with ghost rejection feeding a frame debouncer
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input logic CLOCK_25,
  input logic reset,
  keypad_scanner_if.master kp
);
  logic [3:0]  col_s1, col_s2;
  logic [15:0] slot;
  logic [1:0]  row;
  logic [1:0]  acc_cnt;
  logic [3:0]  acc_code;
  logic        frame_end;
  cand_t       cand;
  logic [3:0]  hits;
  logic [2:0]  row_hits, total;
  logic [1:0]  hit_col;
  logic [3:0]  code_now;
  logic        slot_end;
  always_comb begin
    hits = ~col_s2;
    row_hits = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    hit_col = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
    total = 3'(acc_cnt) + row_hits;
    code_now = row_hits == 3'd1 ? key_map(row, hit_col) : acc_code;
    slot_end = slot == 16'(SCAN_DIV - 1);
  end
  assign kp.row_n = reset ? 4'hf : ~(4'b0001 << row);
  // the frame accumulator saturates at 2 keys: anything beyond one is a reject
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      col_s1 <= 4'hf;
      col_s2 <= 4'hf;
      slot <= '0;
      row <= '0;
      acc_cnt <= '0;
      acc_code <= '0;
      frame_end <= 1'b0;
      cand <= KEY_NONE;
    end else begin
      col_s1 <= kp.col_n;
      col_s2 <= col_s1;
      slot <= slot_end ? '0 : slot + 16'd1;
      frame_end <= slot_end && row == 2'd3;
      if (slot_end) begin
        row <= row + 2'd1;
        acc_cnt <= row == 2'd3 ? 2'd0 : total >= 3'd2 ? 2'd2 : total[1:0];
        acc_code <= row == 2'd3 ? 4'd0 : code_now;
        if (row == 2'd3) cand <= total == 3'd1 ? '{valid: 1'b1, code: code_now} : KEY_NONE;
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk(CLOCK_25),
    .rst(reset),
    .frame_end(frame_end),
    .cand(cand),
    .key_code(kp.key_code),
    .key_pressed(kp.key_pressed),
    .key_event(kp.key_event)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving directed presses; scoreboard checks every output change and its cycle
module tb_keypad_scanner;
  localparam logic [15:0] KEY2 = 16'h0002;
  localparam logic [15:0] KEY8 = 16'h0200;
  typedef struct {
    int         cyc;
    logic       p;
    logic [3:0] code;
    logic       ev;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  col;
  logic [4:0]  last = '0;
  int          cyc = 0;
  int          base = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  keypad_scanner_if kif ();
  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .CLOCK_25(clk),
    .reset(rst),
    .kp(kif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    col = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.row_n[r]) col[c] = 1'b0;
  end
  assign kif.col_n = col;
  function automatic int fb(int f);
    return base + 32 * f;
  endfunction
  task automatic wait_cyc(int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask
  task automatic push(int c, logic p, logic [3:0] code, logic ev);
    q.push_back('{cyc: c, p: p, code: code, ev: ev});
  endtask
  task automatic chk(string name, logic [3:0] got, logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask
  always @(negedge clk) begin
    if ({kif.key_pressed, kif.key_code} !== last || kif.key_event !== 1'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d got p=%b code=%h ev=%b want no change", cyc, kif.key_pressed, kif.key_code, kif.key_event);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.p !== kif.key_pressed || e.code !== kif.key_code || e.ev !== kif.key_event) begin
          bad++;
          $display("FAIL scoreboard got cyc=%0d p=%b code=%h ev=%b want cyc=%0d p=%b code=%h ev=%b",
                   cyc, kif.key_pressed, kif.key_code, kif.key_event, e.cyc, e.p, e.code, e.ev);
        end
      end
      last = {kif.key_pressed, kif.key_code};
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    keys = KEY2;
    wait_cyc(2);
    chk("row_n_in_reset", kif.row_n, 4'b1111);
    wait_cyc(5);
    rst = 1'b0;
    base = cyc;
    #1 chk("row_n_first", kif.row_n, 4'b1110);
    push(base + 97, 1'b1, 4'd2, 1'b1);
    wait_cyc(base + 7);
    chk("row_n_slot0_end", kif.row_n, 4'b1110);
    wait_cyc(base + 8);
    chk("row_n_row1", kif.row_n, 4'b1101);
    wait_cyc(base + 16);
    chk("row_n_row2", kif.row_n, 4'b1011);
    wait_cyc(base + 24);
    chk("row_n_row3", kif.row_n, 4'b0111);
    wait_cyc(base + 32);
    chk("row_n_wrap", kif.row_n, 4'b1110);
    wait_cyc(fb(4));
    keys = KEY2 | KEY8;
    push(fb(7) + 1, 1'b0, 4'd0, 1'b0);
    wait_cyc(fb(9));
    keys = KEY2;
    push(fb(12) + 1, 1'b1, 4'd2, 1'b1);
    wait_cyc(fb(12));
    keys = KEY8;
    push(fb(15) + 1, 1'b1, 4'd8, 1'b1);
    wait_cyc(fb(15));
    keys = '0;
    push(fb(18) + 1, 1'b0, 4'd0, 1'b0);
    wait_cyc(fb(18));
    keys = KEY8;
    wait_cyc(fb(20));
    keys = '0;
    wait_cyc(fb(21));
    keys = KEY8;
    push(fb(24) + 1, 1'b1, 4'd8, 1'b1);
    wait_cyc(fb(24) + 16);
    rst = 1'b1;
    push(fb(24) + 17, 1'b0, 4'd0, 1'b0);
    #1 chk("row_n_reset2", kif.row_n, 4'b1111);
    wait_cyc(fb(24) + 19);
    rst = 1'b0;
    base = cyc;
    push(base + 97, 1'b1, 4'd8, 1'b1);
    #1 chk("row_n_after_reset2", kif.row_n, 4'b1110);
    wait_cyc(base + 140);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter SCAN_DIV, default 25000, clock cycles per row slot (1 ms at 25 MHz); legal range 4..65535.
REQ-003 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scan frames required to accept a result; legal range 1..15.
REQ-004 Port CLOCK_25  input  1  system clock, 25 MHz.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port col_n  input  4  keypad column sense, active-low, asynchronous (externally pulled up).
REQ-007 Port row_n  output  4  keypad row drive, active-low, exactly one bit low outside reset.
REQ-008 Port key_code  output  4  debounced key code; 4'd0 when no key is accepted.
REQ-009 Port key_pressed  output  1  high while a debounced single key is held.
REQ-010 Port key_event  output  1  one-cycle pulse when key_pressed rises or key_code changes while key_pressed is high.

Function
REQ-011 col_n SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Row scan order SHALL be 0,1,2,3,0,...; row r is driven by row_n[r]=0; each row slot lasts exactly SCAN_DIV cycles.
REQ-013 The synchronized columns SHALL be sampled on the last cycle of each row slot; bit c low means key (r,c) is pressed.
REQ-014 Key map (row,col -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: *=E, 0=0, #=F, D. This puts up=4'd2 at (0,1) and down=4'd8 at (2,1).
REQ-015 A frame is the four row slots; at the end of the row-3 slot the frame candidate SHALL be: the key code if exactly one key is pressed, else NONE (zero keys or two or more keys, i.e. ghost rejection).
REQ-016 Debounce: if the candidate equals the previous frame's candidate, the stable counter increments, saturating at DEBOUNCE_SCANS; otherwise it loads 1.
REQ-017 When the stable counter reaches DEBOUNCE_SCANS, the outputs SHALL update one cycle after the frame end: key_pressed = (candidate != NONE), and key_code = candidate code or 4'd0.
REQ-018 key_event SHALL assert for exactly that update cycle when key_pressed goes 0->1, or when key_code changes while key_pressed stays 1; it SHALL NOT assert on release.
REQ-019 Outputs SHALL hold their values between updates; a bounce shorter than DEBOUNCE_SCANS frames SHALL cause no output change.
REQ-020 Latency from a clean press (stable from the start of a frame) to key_pressed=1 SHALL be DEBOUNCE_SCANS frames plus 1 cycle.
REQ-021 The row slot counter and row index SHALL wrap without skipping slots; the frame counter has no other terminal behaviour.

Reset
REQ-022 While reset=1: row_n=4'b1111, key_code=4'd0, key_pressed=0, key_event=0, synchronizer flops=4'b1111, candidate history=NONE, stable counter=0, slot counter=0, row index=0.
REQ-023 The first cycle after reset deasserts SHALL drive row_n=4'b1110 and start a full SCAN_DIV slot.
REQ-024 Reset mid-frame SHALL discard the partial frame and all debounce history, and SHALL NOT pulse key_event.

Structure
REQ-025 Key code constants (KEY_UP=4'd2, KEY_DOWN=4'd8, KEY_NONE) and the SCAN_DIV/DEBOUNCE_SCANS defaults SHALL live in global_symbols.vh so the image generator and this block share them.
REQ-026 Debounce history, counter and output registers SHALL form one sub-module, keypad_debounce, fed by the frame candidate and a frame-end strobe.
REQ-027 Two instances (player 1, player 2) SHALL drive keys_1 and keys_2 of the image generator directly via key_code.

Verification (SCAN_DIV=8, DEBOUNCE_SCANS=3)
REQ-028 Reset held for 5 cycles, then released: row_n=1111 during reset, then 1110; it changes to 1101 exactly 8 cycles later; all outputs stay 0.
REQ-029 col_n[1]=0 only while row 0 is driven, held for 4 frames: key_code=4'd2 and key_pressed=1 three frames plus 1 cycle after the first full frame starts; key_event high for exactly 1 cycle.
REQ-030 Key (2,1) pressed with a 1-frame glitch inserted mid-debounce: no output change until 3 consecutive clean frames have passed, then key_code=4'd8.
REQ-031 Keys (0,1) and (2,1) held simultaneously for 5 frames after 2 accepted: key_pressed falls to 0, key_code=0, and no key_event.
REQ-032 Switch from key 2 directly to key 8: key_code 2->8 accompanied by a single key_event; then release: key_pressed=0 with no key_event.
REQ-033 Reset asserted mid-frame while key 8 is accepted: outputs clear in the same cycle, and re-acceptance takes a full 3 frames after release.
